// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
//   scan_state_e : scanner FSM states (BLANK = all anodes off, DRIVE = one digit lit)
//   NUM_DIGITS   : digits per frame
//   ANODE_OFF    : active-low anode pattern with every digit dark
//   anode_sel()  : active-low one-hot anode enable for a digit index
package display_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  ANODE_OFF  = 4'b1111;

    function automatic logic [3:0] anode_sel(input logic [1:0] sel);
        logic [3:0] onehot;
        onehot    = 4'b0001 << sel;
        anode_sel = ~onehot;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-COUNT up-counter with synchronous clear and enable.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr_i      : force the count to 0 on the next edge (wins over en_i)
//   en_i       : advance the count
//   tc_o       : high in the enabled cycle where the count sits at COUNT-1
module mod_counter #(
    parameter int unsigned COUNT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    // COUNT of 1 would give a zero-width counter; keep one bit that never leaves 0.
    localparam int unsigned W    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with a latched error-pattern override.
//   clk, rst_n  : clock and asynchronous active-low reset
//   set_btn     : synchronised set request level
//   clr_btn     : synchronised reset request level
//   norm_code   : four 4-bit digit codes, [3:0] is digit 0
//   err_code    : code from the external error-pattern mux for the current sel
//   sel         : current digit index
//   an          : active-low anode enables, at most one low
//   code_out    : code for the segment decoder
//   err_active  : high while the error pattern is displayed
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_btn,
    input  logic        clr_btn,
    input  logic [15:0] norm_code,
    input  logic [3:0]  err_code,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [3:0]  code_out,
    output logic        err_active
);

    scan_state_e state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic        err_q, err_d;

    logic blank_en, blank_clr, blank_tc;
    logic pre_en, pre_clr, pre_tc;
    logic both_btn, wrap;

    // Each counter is held at 0 outside its own state and cleared on its
    // terminal count, so it always starts from 0 on state entry.
    assign blank_en  = (state_q == BLANK);
    assign blank_clr = !blank_en || blank_tc;
    assign pre_en    = (state_q == DRIVE);
    assign pre_clr   = !pre_en || pre_tc;

    mod_counter #(
        .COUNT (BLANK_CYC)
    ) u_blank_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (blank_clr),
        .en_i  (blank_en),
        .tc_o  (blank_tc)
    );

    mod_counter #(
        .COUNT (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (pre_clr),
        .en_i  (pre_en),
        .tc_o  (pre_tc)
    );

    assign both_btn = set_btn && clr_btn;
    // Edge on which the last digit finishes and sel returns to 0.
    assign wrap     = pre_tc && (sel_q == 2'(NUM_DIGITS - 1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            BLANK: begin
                if (blank_tc) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (pre_tc) begin
                    state_d = BLANK;
                    sel_d   = sel_q + 2'd1;
                end
            end
            default: state_d = BLANK;
        endcase

        // Error latches on both buttons; it is only released at a frame
        // boundary, and only if both buttons are idle at that moment.
        err_d = err_q;
        if (both_btn) begin
            err_d = 1'b1;
        end else if (!set_btn && !clr_btn && wrap) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            sel_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    // Anodes only ever toggle between all-off and a single digit, since sel
    // changes exclusively on the DRIVE->BLANK edge.
    assign an         = (state_q == DRIVE) ? anode_sel(sel_q) : ANODE_OFF;
    assign sel        = sel_q;
    assign err_active = err_q;
    assign code_out   = err_q ? err_code : norm_code[{sel_q, 2'b00} +: 4];

endmodule

// File: tb/tb_display_scan_ctrl.sv
`timescale 1ns / 1ps
module tb_display_scan_ctrl;

    localparam int unsigned REFRESH_DIV = 4;
    localparam int unsigned BLANK_CYC   = 2;
    localparam int          DIGIT_P     = REFRESH_DIV + BLANK_CYC;   // 6
    localparam int          FRAME_P     = 4 * DIGIT_P;               // 24

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] code;
        logic       err;
        logic [1:0] sel;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        set_btn = 1'b0;
    logic        clr_btn = 1'b0;
    logic [15:0] norm_code = 16'h4321;
    logic [3:0]  err_code;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [3:0]  code_out;
    logic        err_active;

    int   checks = 0;
    int   errors = 0;
    int   k = 0;                 // rising edges since reset release
    logic exp_err = 1'b0;
    obs_t sb_q[$];
    obs_t exp_o, act_o;

    // Bench-side error-pattern mux: a code that encodes the digit index.
    assign err_code = {2'b10, sel};

    display_scan_ctrl #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_btn    (set_btn),
        .clr_btn    (clr_btn),
        .norm_code  (norm_code),
        .err_code   (err_code),
        .sel        (sel),
        .an         (an),
        .code_out   (code_out),
        .err_active (err_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got t=%0t want finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Expected outputs from the edge count since reset: each digit shows
    // BLANK_CYC dark cycles then REFRESH_DIV lit cycles.
    function automatic obs_t expect_now();
        int         phase;
        logic [1:0] d;
        logic [3:0] onehot;
        obs_t       o;
        phase  = k % FRAME_P;
        d      = 2'(phase / DIGIT_P);
        onehot = 4'b0001 << d;
        o.an   = ((phase % DIGIT_P) < BLANK_CYC) ? 4'hF : ~onehot;
        o.code = exp_err ? {2'b10, d} : norm_code[{d, 2'b00} +: 4];
        o.err  = exp_err;
        o.sel  = d;
        return o;
    endfunction

    // One clock: update the error model at the edge, then queue the expected
    // outputs for the following falling-edge sample.
    task automatic advance();
        @(posedge clk);
        if (set_btn && clr_btn) begin
            exp_err = 1'b1;
        end else if (!set_btn && !clr_btn && (k % FRAME_P) == FRAME_P - 1) begin
            exp_err = 1'b0;
        end
        k++;
        @(negedge clk);
        sb_q.push_back(expect_now());
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        k       = 0;
        exp_err = 1'b0;
        sb_q.delete();
        sb_q.push_back(expect_now());
    endtask

    function automatic int cycles_to(input int phase);
        return (phase - (k % FRAME_P) + FRAME_P) % FRAME_P;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        act_o = {an, code_out, err_active, sel};
        exp_o = {4'hF, norm_code[3:0], 1'b0, 2'd0};
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL reset_hold got an/code/err/sel=%b/%h/%b/%0d want %b/%h/%b/%0d",
                     act_o.an, act_o.code, act_o.err, act_o.sel,
                     exp_o.an, exp_o.code, exp_o.err, exp_o.sel);
        end
        release_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) advance();
            exp_o = sb_q.pop_front();
            act_o = {an, code_out, err_active, sel};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL reset_start k=%0d got an/code/err/sel=%b/%h/%b/%0d want %b/%h/%b/%0d",
                         k, act_o.an, act_o.code, act_o.err, act_o.sel,
                         exp_o.an, exp_o.code, exp_o.err, exp_o.sel);
            end
        end
    endtask

    task automatic test_scan();
        for (int i = 0; i < 2 * FRAME_P + 4; i++) begin
            if (i == FRAME_P) norm_code = 16'hA5C3;
            advance();
            exp_o = sb_q.pop_front();
            act_o = {an, code_out, err_active, sel};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL scan k=%0d got an/code/err/sel=%b/%h/%b/%0d want %b/%h/%b/%0d",
                         k, act_o.an, act_o.code, act_o.err, act_o.sel,
                         exp_o.an, exp_o.code, exp_o.err, exp_o.sel);
            end
        end
    endtask

    task automatic test_single_button();
        for (int i = 0; i < 20; i++) begin
            set_btn = (i < 10);
            clr_btn = (i >= 10);
            advance();
            exp_o = sb_q.pop_front();
            act_o = {an, code_out, err_active, sel};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL single_btn k=%0d got an/code/err/sel=%b/%h/%b/%0d want %b/%h/%b/%0d",
                         k, act_o.an, act_o.code, act_o.err, act_o.sel,
                         exp_o.an, exp_o.code, exp_o.err, exp_o.sel);
            end
        end
        set_btn = 1'b0;
        clr_btn = 1'b0;
    endtask

    // One-cycle pulse of both buttons while digit 1 is lit.
    task automatic test_error();
        int n;
        n = cycles_to(9);
        for (int i = 0; i < n + 34; i++) begin
            set_btn = (i == n);
            clr_btn = (i == n);
            advance();
            exp_o = sb_q.pop_front();
            act_o = {an, code_out, err_active, sel};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL error k=%0d got an/code/err/sel=%b/%h/%b/%0d want %b/%h/%b/%0d",
                         k, act_o.an, act_o.code, act_o.err, act_o.sel,
                         exp_o.an, exp_o.code, exp_o.err, exp_o.sel);
            end
        end
        set_btn = 1'b0;
        clr_btn = 1'b0;
    endtask

    // Error raised in digit 0; both buttons held again from digit 2 across the wrap.
    task automatic test_cancel();
        int n;
        n = cycles_to(4);
        for (int i = 0; i < n + 52; i++) begin
            set_btn = (i == n) || (i >= n + 10 && i <= n + 21);
            clr_btn = set_btn;
            advance();
            exp_o = sb_q.pop_front();
            act_o = {an, code_out, err_active, sel};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL cancel k=%0d got an/code/err/sel=%b/%h/%b/%0d want %b/%h/%b/%0d",
                         k, act_o.an, act_o.code, act_o.err, act_o.sel,
                         exp_o.an, exp_o.code, exp_o.err, exp_o.sel);
            end
        end
        set_btn = 1'b0;
        clr_btn = 1'b0;
    endtask

    // Reset dropped between edges while digit 2 is lit with the error shown.
    task automatic test_reset_mid();
        int n;
        n = cycles_to(13);
        for (int i = 0; i < n + 2; i++) begin
            set_btn = (i == n);
            clr_btn = (i == n);
            advance();
            exp_o = sb_q.pop_front();
            act_o = {an, code_out, err_active, sel};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL pre_reset k=%0d got an/code/err/sel=%b/%h/%b/%0d want %b/%h/%b/%0d",
                         k, act_o.an, act_o.code, act_o.err, act_o.sel,
                         exp_o.an, exp_o.code, exp_o.err, exp_o.sel);
            end
        end
        set_btn = 1'b0;
        clr_btn = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        act_o = {an, code_out, err_active, sel};
        exp_o = {4'hF, norm_code[3:0], 1'b0, 2'd0};
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL async_reset got an/code/err/sel=%b/%h/%b/%0d want %b/%h/%b/%0d",
                     act_o.an, act_o.code, act_o.err, act_o.sel,
                     exp_o.an, exp_o.code, exp_o.err, exp_o.sel);
        end
        @(posedge clk);
        release_reset();
        for (int i = 0; i < 14; i++) begin
            if (i > 0) advance();
            exp_o = sb_q.pop_front();
            act_o = {an, code_out, err_active, sel};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL post_reset k=%0d got an/code/err/sel=%b/%h/%b/%0d want %b/%h/%b/%0d",
                         k, act_o.an, act_o.code, act_o.err, act_o.sel,
                         exp_o.an, exp_o.code, exp_o.err, exp_o.sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single_button();
        test_error();
        test_cancel();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 100000, giving the clock cycles each digit is driven; legal range >= 2.
REQ-002 SHALL provide parameter BLANK_CYC, default 16, giving the all-anodes-off cycles between digits; legal range >= 1.
REQ-003 SHALL have port clk, input, 1 bit, single rising-edge clock for all state.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port set_btn, input, 1 bit, synchronised set request level.
REQ-006 SHALL have port clr_btn, input, 1 bit, synchronised reset request level.
REQ-007 SHALL have port norm_code, input, 16 bits, four 4-bit digit codes, with [3:0] as digit 0 and [15:12] as digit 3.
REQ-008 SHALL have port err_code, input, 4 bits, code returned by the error-pattern mux for the current sel.
REQ-009 SHALL have port sel, output, 2 bits, current digit index, fed to the error-pattern mux and to the normal path.
REQ-010 SHALL have port an, output, 4 bits, active-low anode enables, with at most one bit low.
REQ-011 SHALL have port code_out, output, 4 bits, code for the segment decoder.
REQ-012 SHALL have port err_active, output, 1 bit, high while the error pattern is displayed.

Function
REQ-013 SHALL implement FSM states BLANK and DRIVE.
REQ-014 BLANK SHALL hold an=4'b1111 for exactly BLANK_CYC cycles, then enter DRIVE.
REQ-015 DRIVE SHALL drive an=~(4'b0001<<sel) for exactly REFRESH_DIV cycles.
REQ-016 On the last DRIVE cycle, the block SHALL enter BLANK and increment sel modulo 4, so sel 3 wraps to 0 in that same cycle.
REQ-017 The digit period SHALL be BLANK_CYC+REFRESH_DIV cycles, and the frame SHALL be 4x that.
REQ-018 The prescaler and blank counters SHALL each clear to 0 on state entry, and their widths SHALL be sized with $clog2 of their parameters.
REQ-019 code_out SHALL be combinational from registered state: err_code when err_active=1, otherwise norm_code[4*sel +: 4].
REQ-020 err_active SHALL rise on the clock edge following a cycle in which set_btn and clr_btn are both 1, regardless of FSM state.
REQ-021 err_active SHALL remain set while either button is 1.
REQ-022 Once both buttons are 0, err_active SHALL clear only on the edge where sel wraps 3->0, so that a complete error frame is always shown.
REQ-023 If both buttons are high again before that wrap, the pending clear SHALL be cancelled.
REQ-024 Asserting set_btn alone or clr_btn alone SHALL NOT affect err_active or the scan timing.
REQ-025 The block SHALL NOT produce an anode glitch: an SHALL change only from 1111 to one-hot-low, or from one-hot-low to 1111.

Reset
REQ-026 While rst_n=0, all of the following SHALL be forced immediately: state=BLANK, sel=0, an=4'b1111, counters=0, err_active=0.
REQ-027 With rst_n=0, code_out SHALL therefore equal norm_code[3:0].
REQ-028 After rst_n deasserts, the first DRIVE (sel=0) SHALL begin after exactly BLANK_CYC clock edges.
REQ-029 Reset asserted mid-DRIVE or while in error SHALL abandon the digit and the error state with no residual effect.

Structure
REQ-030 Package display_pkg SHALL hold the state enum (BLANK, DRIVE), the constant NUM_DIGITS=4 and the constant ANODE_OFF=4'b1111.
REQ-031 One sub-module, mod_counter (parameterised terminal count, clear, enable, terminal-count flag), SHALL be instantiated for both the prescaler and the blank counter.

Verification (REFRESH_DIV=4, BLANK_CYC=2)
REQ-032 Scenario: release reset, norm_code=16'h4321 -> an shows 1111 for 2 cycles, then 1110 for 4 cycles with code_out=1, then 1111 for 2, then 1101 with code_out=2; the pattern repeats every 24 cycles.
REQ-033 Scenario: run past sel=3 -> sel wraps to 0 at the 3->BLANK transition, and an never shows two low bits.
REQ-034 Scenario: pulse set_btn and clr_btn together for 1 cycle during sel=1 -> err_active=1 next cycle, code_out=err_code, and err_active stays 1 until the next 3->0 wrap, then 0.
REQ-035 Scenario: set_btn=1 only for 10 cycles -> err_active stays 0 and the scan timing is unchanged.
REQ-036 Scenario: error pending clear, both buttons reasserted at sel=2 -> err_active is still 1 after the wrap.
REQ-037 Scenario: assert rst_n=0 mid-DRIVE at sel=2 with err_active=1 -> an=1111, sel=0 and err_active=0 with no clock edge.
